sun_tracker_sched: RTL

Sequencing controller for the two-axis solar tracker. It compares light-sensor pairs for the frame axis (left/right) and the panel axis (top/bottom) and drives the BTN_0/BTN_1 direction inputs of the two `servo_driver` instances. Servo moves are time-sliced, so at most one servo is ever commanded at a time. Each move is a fixed-length burst followed by a settle period and a fresh sample.

---
 rtl/sun_tracker_sched_if.sv | 18 +
 rtl/sun_tracker_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sun_tracker_sched_if.sv
// sun_tracker_sched_if: sensor-sample and servo-command bundle of the solar tracker sequencer
//   master: drives en_i, smp_valid_i, ldr_{l,r,t,b}_i; observes commands and status
//   slave : the tracker; drives {frame,panel}_btn_{0,1}_o, axis_o, busy_o, fault_o
interface sun_tracker_sched_if #(parameter int DW = 10);
    logic          en_i;
    logic          smp_valid_i;
    logic [DW-1:0] ldr_l_i, ldr_r_i, ldr_t_i, ldr_b_i;
    logic          frame_btn_0_o, frame_btn_1_o, panel_btn_0_o, panel_btn_1_o;
    logic          axis_o, busy_o, fault_o;
    modport master (
        output en_i, smp_valid_i, ldr_l_i, ldr_r_i, ldr_t_i, ldr_b_i,
        input  frame_btn_0_o, frame_btn_1_o, panel_btn_0_o, panel_btn_1_o, axis_o, busy_o, fault_o
    );
    modport slave (
        input  en_i, smp_valid_i, ldr_l_i, ldr_r_i, ldr_t_i, ldr_b_i,
        output frame_btn_0_o, frame_btn_1_o, panel_btn_0_o, panel_btn_1_o, axis_o, busy_o, fault_o
    );
endinterface

// File: rtl/sun_tracker_sched.sv
// sun_tracker_sched: time-sliced two-axis solar tracker sequencer driving two servo_driver direction pairs
//   clk_i  : system clock
//   rst_ni : synchronous active-low reset
//   bus    : sun_tracker_sched_if.slave (enable, sample strobe, four LDR readings, BTN commands, status)
//   Optional: define TRACKER_TIMEOUT_EN to build the per-axis move limit and the sticky fault flag.
module sun_tracker_sched #(
    parameter int DW         = 10,
    parameter int HYST       = 8,
    parameter int MOVE_CYC   = 50000,
    parameter int SETTLE_CYC = 100000,
    parameter int MAX_MOVES  = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sun_tracker_sched_if.slave bus
);
    localparam int CMAX = MOVE_CYC > SETTLE_CYC ? MOVE_CYC : SETTLE_CYC;
    localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
    typedef enum logic [2:0] {IDLE, WAIT_SMP, EVAL, DECIDE, MOVE, SETTLE, NEXT} state_t;
    state_t        state_q;
    logic [DW-1:0] a_q, b_q;
    logic          pos_q, neg_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    btn_q;
    logic          axis_q, busy_q;
    logic signed [DW:0] d_d;
    logic          pos_d, neg_d, timeout_d;
    assign d_d   = $signed({1'b0, a_q}) - $signed({1'b0, b_q});
    assign pos_d = int'(d_d) > HYST;
    assign neg_d = int'(d_d) < -HYST;
`ifdef TRACKER_TIMEOUT_EN
    localparam int MW = $clog2(MAX_MOVES + 1);
    logic [MW-1:0] mv_q;
    logic          fault_q;
    assign timeout_d   = mv_q == MW'(MAX_MOVES);
    assign bus.fault_o = fault_q;
`else
    assign timeout_d   = 1'b0;
    assign bus.fault_o = 1'b0;
`endif
    // btn_q bit order: {panel_1, panel_0, frame_1, frame_0}
    assign bus.frame_btn_0_o = btn_q[0];
    assign bus.frame_btn_1_o = btn_q[1];
    assign bus.panel_btn_0_o = btn_q[2];
    assign bus.panel_btn_1_o = btn_q[3];
    assign bus.axis_o        = axis_q;
    assign bus.busy_o        = busy_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            btn_q   <= '0;
            axis_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef TRACKER_TIMEOUT_EN
            mv_q    <= '0;
            fault_q <= 1'b0;
`endif
        end else if (!bus.en_i) begin
            // Dropping enable aborts anything in flight, including a round-end NEXT; fault is kept.
            state_q <= IDLE;
            cnt_q   <= '0;
            btn_q   <= '0;
            axis_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef TRACKER_TIMEOUT_EN
            mv_q    <= '0;
`endif
        end else begin
            busy_q <= 1'b1;
            case (state_q)
                IDLE: state_q <= WAIT_SMP;
                WAIT_SMP: if (bus.smp_valid_i) begin
                    a_q     <= axis_q ? bus.ldr_t_i : bus.ldr_l_i;
                    b_q     <= axis_q ? bus.ldr_b_i : bus.ldr_r_i;
                    state_q <= EVAL;
                end
                // Comparison is registered so the decision and the BTN edge land two edges after the strobe.
                EVAL: begin
                    pos_q   <= pos_d;
                    neg_q   <= neg_d;
                    state_q <= DECIDE;
                end
                DECIDE: if (!(pos_q || neg_q) || timeout_d) begin
`ifdef TRACKER_TIMEOUT_EN
                    if (pos_q || neg_q) fault_q <= 1'b1;
`endif
                    state_q <= NEXT;
                end else begin
`ifdef TRACKER_TIMEOUT_EN
                    mv_q    <= mv_q + 1'b1;
`endif
                    btn_q   <= 4'b0001 << {axis_q, neg_q};
                    cnt_q   <= '0;
                    state_q <= MOVE;
                end
                MOVE: if (cnt_q == CW'(MOVE_CYC - 1)) begin
                    btn_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SETTLE;
                end else cnt_q <= cnt_q + 1'b1;
                SETTLE: if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    cnt_q   <= '0;
                    state_q <= WAIT_SMP;
                end else cnt_q <= cnt_q + 1'b1;
                NEXT: begin
                    axis_q  <= !axis_q;
`ifdef TRACKER_TIMEOUT_EN
                    mv_q    <= '0;
`endif
                    state_q <= WAIT_SMP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
